id_addr_mapper: RTL and testbench
=================================

# id_addr_mapper

Parametrised, programmable ID-to-address mapper for the identity-check datapath. It accepts an ID code from the reader front end with a valid/ready handshake and searches a DEPTH-entry register table sequentially. It returns a one-cycle response carrying a hit flag and the matching entry index, which the downstream user-record memory uses as its address. Table entries are written at runtime through a separate write port. Unknown IDs are reported as misses instead of being silently held.

## Interface
- ID_W, 3, width of the ID code
- DEPTH, 8, number of table entries (2..2^ADDR_W)
- ADDR_W, 4, width of rsp_addr and wr_idx
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  lookup request present
- req_ready  out  1  mapper can accept a request
- req_id  in  ID_W  ID to look up
- rsp_valid  out  1  one-cycle response strobe
- rsp_hit  out  1  ID found (qualified by rsp_valid)
- rsp_addr  out  ADDR_W  index of matching entry
- wr_en  in  1  table write strobe
- wr_idx  in  ADDR_W  entry to write
- wr_id  in  ID_W  ID stored in the entry
- wr_vld  in  1  entry valid bit (0 = clear entry)
- busy  out  1  search in progress

## Operation
- States: IDLE, SEARCH, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, the block latches req_id, sets idx=0, and moves to SEARCH.
- SEARCH: req_ready=0 and busy=1. Each cycle the block compares table[idx]. If the entry is valid and matches: rsp_hit<=1, rsp_addr<=idx, next state RESP. Else, if idx==DEPTH-1: rsp_hit<=0 and rsp_addr holds its previous value, next state RESP. Else idx<=idx+1.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. No request is accepted in RESP.
- Duplicate IDs in the table: the lowest index wins.
- Writes are accepted in every state. A write lands at the clock edge. A compare in the same cycle as a write to the same entry uses the old contents.
- A write with wr_idx>=DEPTH is ignored.
- Reset outputs: req_ready=0 while rst is asserted, then 1 in IDLE. rsp_valid=0, rsp_hit=0, rsp_addr=0, busy=0. All table valid bits are 0 unless the macro described under Configuration is defined.
- Reset asserted mid-search aborts the lookup. No response is issued for it.

## Timing
- The accept edge is T0.
- A match at index k gives rsp_valid high in the cycle after edge T(k+1).
- A miss gives rsp_valid high in the cycle after edge T(DEPTH).
- Minimum spacing between accepts is k+3 cycles: SEARCH, RESP, then IDLE.
- rsp_hit and rsp_addr remain stable after the strobe until the next response.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- ID_MAPPER_DEFAULT_TABLE_EN defined: reset loads entries 0..4 with IDs 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, all valid. The remaining entries are invalid.
- This mode requires ID_W=3 and DEPTH>=5; any other combination is an elaboration error.
- ID_MAPPER_DEFAULT_TABLE_EN undefined: every entry resets invalid, and firmware must program the table before use.

## Structure
- Package id_mapper_pkg holds:
  - the state enum typedef (IDLE/SEARCH/RESP);
  - the default-table ID constants;
  - the default entry count (5).
- Sub-module id_table holds the DEPTH entries (ID plus valid bit). It has a write port and an index-read port and contains the reset/default loading.
- The FSM, the index counter and the response registers stay in the top level.

## Test plan
- Default table defined; request ID 3'b101 → rsp_valid after 4 cycles (k=3), rsp_hit=1, rsp_addr=3.
- Default table defined; request ID 3'b111 → rsp_valid after DEPTH=8 edges, rsp_hit=0, rsp_addr unchanged from the previous response.
- Write idx 6 with ID 3'b100, then request 3'b100 → rsp_hit=1, rsp_addr=6. Clear idx 6 (wr_vld=0), repeat the request → miss.
- Write ID 3'b010 to both idx 1 and idx 5 → response addr=1. Write to idx 1 in the same cycle it is compared → old contents decide the result.
- Assert rst at cycle 2 of a search → no rsp_valid, outputs return to reset values, and the next request completes normally.
- Hold req_valid during SEARCH and RESP → only one accept per lookup. wr_idx=9 with DEPTH=8 → table unchanged.

Source files
------------

// File: rtl/id_mapper_pkg.sv
// Shared types and default-table contents for the ID-to-address mapper.
// The defaults are used only when ID_MAPPER_DEFAULT_TABLE_EN is defined.
package id_mapper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_ENTRY_CNT = 5;
  localparam int DEF_ID_W      = 3;

  localparam logic [DEF_ID_W-1:0] DEF_ID_0 = 3'b001;
  localparam logic [DEF_ID_W-1:0] DEF_ID_1 = 3'b010;
  localparam logic [DEF_ID_W-1:0] DEF_ID_2 = 3'b011;
  localparam logic [DEF_ID_W-1:0] DEF_ID_3 = 3'b101;
  localparam logic [DEF_ID_W-1:0] DEF_ID_4 = 3'b110;

  // Entries at or beyond DEF_ENTRY_CNT have no default ID.
  function automatic logic [DEF_ID_W-1:0] def_table_id(input int idx);
    logic [DEF_ID_W-1:0] id;
    case (idx)
      0:       id = DEF_ID_0;
      1:       id = DEF_ID_1;
      2:       id = DEF_ID_2;
      3:       id = DEF_ID_3;
      4:       id = DEF_ID_4;
      default: id = '0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/id_table.sv
// DEPTH-entry ID table (ID plus valid bit) with one write port and one index-read port.
// With ID_MAPPER_DEFAULT_TABLE_EN defined, reset preloads the default IDs.
module id_table
  import id_mapper_pkg::*;
#(
  parameter int ID_W   = 3,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [ID_W-1:0]   wr_id,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [ID_W-1:0]   rd_id,
  output logic              rd_vld
);

  logic [DEPTH-1:0][ID_W-1:0] ent_id;
  logic [DEPTH-1:0]           ent_vld;

`ifdef ID_MAPPER_DEFAULT_TABLE_EN
  generate
    if (ID_W != DEF_ID_W || DEPTH < DEF_ENTRY_CNT) begin : g_bad_cfg
      $error("id_table: default table needs ID_W=3 and DEPTH>=5");
    end
  endgenerate
`endif

  // Only indices below DEPTH decode, so out-of-range writes fall through untouched.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
`ifdef ID_MAPPER_DEFAULT_TABLE_EN
      localparam logic [ID_W-1:0] RST_ID  = (gi < DEF_ENTRY_CNT) ? ID_W'(def_table_id(gi)) : '0;
      localparam logic            RST_VLD = (gi < DEF_ENTRY_CNT);
`else
      localparam logic [ID_W-1:0] RST_ID  = '0;
      localparam logic            RST_VLD = 1'b0;
`endif
      logic [ID_W-1:0] id_q, id_d;
      logic            vld_q, vld_d;
      logic            wr_sel;

      assign wr_sel = wr_en && (wr_idx == ADDR_W'(gi));

      always_comb begin
        id_d  = id_q;
        vld_d = vld_q;
        if (wr_sel) begin
          id_d  = wr_id;
          vld_d = wr_vld;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          id_q  <= RST_ID;
          vld_q <= RST_VLD;
        end else begin
          id_q  <= id_d;
          vld_q <= vld_d;
        end
      end

      assign ent_id[gi]  = id_q;
      assign ent_vld[gi] = vld_q;
    end
  endgenerate

  always_comb begin
    rd_id  = '0;
    rd_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == ADDR_W'(i)) begin
        rd_id  = ent_id[i];
        rd_vld = ent_vld[i];
      end
    end
  end

endmodule

// File: rtl/id_addr_mapper.sv
// Sequential ID-to-address lookup: one table entry compared per cycle, lowest index wins.
// Optional reset-time table preload via ID_MAPPER_DEFAULT_TABLE_EN (see id_table).
module id_addr_mapper
  import id_mapper_pkg::*;
#(
  parameter int ID_W   = 3,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [ID_W-1:0]   wr_id,
  input  logic              wr_vld,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              busy_q, busy_d;
  logic              req_ready_q, req_ready_d;

  logic [ID_W-1:0]   tbl_id;
  logic              tbl_vld;

  id_table #(
    .ID_W   (ID_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_id  (wr_id),
    .wr_vld (wr_vld),
    .rd_idx (idx_q),
    .rd_id  (tbl_id),
    .rd_vld (tbl_vld)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    id_d        = id_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = rsp_hit_q;
    rsp_addr_d  = rsp_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          id_d    = req_id;
          idx_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (tbl_vld && (tbl_id == id_q)) begin
          rsp_hit_d   = 1'b1;
          rsp_addr_d  = idx_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (idx_q == LAST_IDX) begin
          // Miss keeps the previous address so downstream sees a stable value.
          rsp_hit_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d == SEARCH);
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_addr  = rsp_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_id_addr_mapper.sv
// Scoreboard bench for id_addr_mapper: expectations come from a behavioural table model.
// Works with or without ID_MAPPER_DEFAULT_TABLE_EN defined.
module tb_id_addr_mapper;

  localparam int ID_W   = 3;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ID_W-1:0]   req_id = '0;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [ADDR_W-1:0] rsp_addr;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_idx = '0;
  logic [ID_W-1:0]   wr_id = '0;
  logic              wr_vld = 1'b0;
  logic              busy;

  always #5 clk = ~clk;

  id_addr_mapper #(
    .ID_W   (ID_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_addr  (rsp_addr),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_id     (wr_id),
    .wr_vld    (wr_vld),
    .busy      (busy)
  );

  typedef struct {
    logic              hit;
    logic [ADDR_W-1:0] addr;
    int                lat;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [ID_W-1:0]   mdl_id  [DEPTH];
  logic              mdl_vld [DEPTH];
  logic [ADDR_W-1:0] mdl_last_addr;

  int cyc         = 0;
  int last_accept = 0;
  int accept_cnt  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_id[i]  = '0;
      mdl_vld[i] = 1'b0;
    end
`ifdef ID_MAPPER_DEFAULT_TABLE_EN
    mdl_id[0] = 3'b001; mdl_vld[0] = 1'b1;
    mdl_id[1] = 3'b010; mdl_vld[1] = 1'b1;
    mdl_id[2] = 3'b011; mdl_vld[2] = 1'b1;
    mdl_id[3] = 3'b101; mdl_vld[3] = 1'b1;
    mdl_id[4] = 3'b110; mdl_vld[4] = 1'b1;
`endif
    mdl_last_addr = '0;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) begin
      last_accept <= cyc + 1;
      accept_cnt  <= accept_cnt + 1;
    end
  end

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rsp hit=%0b addr=%0d lat=%0d (exp hit=%0b addr=%0d lat=%0d)",
                 rsp_hit, rsp_addr, cyc - last_accept, e.hit, e.addr, e.lat);
        check_val("rsp_hit", 32'(rsp_hit), 32'(e.hit));
        check_val("rsp_addr", 32'(rsp_addr), 32'(e.addr));
        check_val("rsp_lat", 32'(cyc - last_accept), 32'(e.lat));
      end
    end
  end

  task automatic wr(input logic [ADDR_W-1:0] idx, input logic [ID_W-1:0] id, input logic vld);
    wr_en  = 1'b1;
    wr_idx = idx;
    wr_id  = id;
    wr_vld = vld;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (int'(idx) < DEPTH) begin
      mdl_id[idx]  = id;
      mdl_vld[idx] = vld;
    end
    $display("write idx=%0d id=%0b vld=%0b", idx, id, vld);
  endtask

  task automatic issue_req(input logic [ID_W-1:0] id, input bit hold);
    exp_t e;
    bit   rdy;
    rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        rdy = 1'b1;
        break;
      end
    end
    check_val("ready_wait", 32'(rdy), 32'd1);
    e.hit  = 1'b0;
    e.addr = mdl_last_addr;
    for (int i = 0; i < DEPTH; i++) begin
      if (!e.hit && mdl_vld[i] && mdl_id[i] == id) begin
        e.hit  = 1'b1;
        e.addr = ADDR_W'(i);
      end
    end
    e.lat = e.hit ? int'(e.addr) + 1 : DEPTH;
    mdl_last_addr = e.addr;
    sb.push_back(e);
    $display("req id=%0b", id);
    req_valid = 1'b1;
    req_id    = id;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    check_val("busy_search", 32'(busy), 32'd1);
    check_val("ready_search", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_rsp(input bit hold);
    bit got;
    got = 1'b0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check_val("rsp_seen", 32'(got), 32'd1);
    if (hold) req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [ID_W-1:0] id);
    issue_req(id, 1'b0);
    wait_rsp(1'b0);
  endtask

  task automatic program_defaults();
`ifndef ID_MAPPER_DEFAULT_TABLE_EN
    wr(4'd0, 3'b001, 1'b1);
    wr(4'd1, 3'b010, 1'b1);
    wr(4'd2, 3'b011, 1'b1);
    wr(4'd3, 3'b101, 1'b1);
    wr(4'd4, 3'b110, 1'b1);
`endif
  endtask

  initial begin
    int acc0;
    mdl_reset();
    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check_val("rst_rsp_addr", 32'(rsp_addr), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef ID_MAPPER_DEFAULT_TABLE_EN
    lookup(3'b001);
`endif
    program_defaults();

    lookup(3'b101);
    lookup(3'b111);
    lookup(3'b001);

    wr(4'd6, 3'b100, 1'b1);
    lookup(3'b100);
    wr(4'd6, 3'b100, 1'b0);
    lookup(3'b100);

    wr(4'd5, 3'b010, 1'b1);
    lookup(3'b010);

    // Overwrite idx 1 during the cycle it is being compared: old contents decide.
    issue_req(3'b010, 1'b0);
    @(posedge clk);
    #1;
    wr_en  = 1'b1;
    wr_idx = 4'd1;
    wr_id  = 3'b111;
    wr_vld = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    mdl_id[1]  = 3'b111;
    mdl_vld[1] = 1'b1;
    $display("write idx=1 id=111 vld=1 during compare");
    wait_rsp(1'b0);
    lookup(3'b010);

    wr(4'd9, 3'b100, 1'b1);
    lookup(3'b100);

    acc0 = accept_cnt;
    issue_req(3'b110, 1'b1);
    wait_rsp(1'b1);
    repeat (3) @(negedge clk);
    check_val("hold_accepts", 32'(accept_cnt - acc0), 32'd1);

    issue_req(3'b111, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    check_val("mid_rst_ready", 32'(req_ready), 32'd0);
    check_val("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("mid_rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check_val("mid_rst_rsp_addr", 32'(rsp_addr), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_reset();
    $display("reset during search");
    repeat (DEPTH + 4) @(negedge clk);
    check_val("post_rst_busy", 32'(busy), 32'd0);
`ifndef ID_MAPPER_DEFAULT_TABLE_EN
    wr(4'd2, 3'b011, 1'b1);
`endif
    lookup(3'b011);
    check_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
